// File: rtl/dvp_rx_pkg.sv
// Shared definitions for the DVP receive path: scheduler state encoding,
// AXI response codes and the default bus geometry.
package dvp_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_ISSUE,
        ST_WAIT_W,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         BYTES_PER_BEAT = 4;
    localparam int         KB4_BYTES      = 4096;

    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dvp_outst_cnt.sv
// Tracks AXI write bursts whose B response has not yet been accepted.
module dvp_outst_cnt #(
    parameter int MAX_OUTST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0] count_reg;

    // Simultaneous increment and decrement cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && !dec) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec && !inc && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign full  = (count_reg == CNT_W'(MAX_OUTST));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/dvp_burst_scheduler.sv
// Issues AXI AW bursts for a DVP frame from FIFO fill level, ping/pong buffers.
// Define DVP_BURST_SCHED_4KB_EN to clip bursts at 4 KB address boundaries.
module dvp_burst_scheduler
    import dvp_rx_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = BYTES_PER_BEAT * 8,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int MST_ID_W         = 5,
    parameter int MAX_OUTST        = 4,
    parameter int LVL_W            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_en_i,
    input  logic [ADDR_W-1:0]           cfg_base0_i,
    input  logic [ADDR_W-1:0]           cfg_base1_i,
    input  logic [19:0]                 cfg_frm_words_i,
    input  logic [7:0]                  cfg_burst_len_i,
    input  logic [LVL_W-1:0]            fifo_lvl_i,
    input  logic                        frm_start_i,
    input  logic                        frm_end_i,
    output logic                        awvalid_o,
    input  logic                        awready_i,
    output logic [ADDR_W-1:0]           awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] awlen_o,
    output logic [MST_ID_W-1:0]         awid_o,
    output logic                        burst_go_o,
    output logic [8:0]                  burst_beats_o,
    input  logic                        burst_done_i,
    input  logic                        bvalid_i,
    input  logic [1:0]                  bresp_i,
    output logic                        bready_o,
    output logic                        frm_done_o,
    output logic                        buf_sel_o,
    output logic                        err_o,
    output logic                        busy_o
);

    localparam int BPB    = beat_bytes(DATA_W);
    localparam int BPB_SH = $clog2(BPB);

    sched_state_t                state_reg, state_next;
    logic [ADDR_W-1:0]           addr_reg, addr_next;
    logic [19:0]                 remaining_reg, remaining_next;
    logic [8:0]                  burst_len_reg, burst_len_next;
    logic [8:0]                  beats_reg, beats_next;
    logic [TRANS_DATA_LEN_W-1:0] awlen_reg, awlen_next;
    logic                        frm_end_reg;
    logic                        buf_sel_reg;
    logic                        err_reg;
    logic                        burst_go_reg;

    logic        awvalid;
    logic        aw_hs;
    logic        b_hs;
    logic        outst_full;
    logic        outst_empty;
    logic [8:0]  beats_calc;
    logic        lvl_ok;
    logic [19:0] remaining_after;

    assign awvalid         = (state_reg == ST_ISSUE);
    assign aw_hs           = awvalid && awready_i;
    assign b_hs            = bvalid_i && !outst_empty;
    assign remaining_after = remaining_reg - 20'(beats_reg);

`ifdef DVP_BURST_SCHED_4KB_EN
    logic [12:0] bytes_to_4kb;
    logic [12:0] beats_to_4kb;

    assign bytes_to_4kb = 13'(KB4_BYTES) - {1'b0, addr_reg[11:0]};
    assign beats_to_4kb = (bytes_to_4kb >> BPB_SH) == '0 ? 13'd1 : (bytes_to_4kb >> BPB_SH);
`endif

    // Burst size candidate: nominal length, trimmed by frame tail, boundary and flush.
    always_comb begin
        beats_calc = burst_len_reg;
        if (remaining_reg < 20'(burst_len_reg)) begin
            beats_calc = remaining_reg[8:0];
        end
`ifdef DVP_BURST_SCHED_4KB_EN
        if (beats_to_4kb < {4'b0, beats_calc}) begin
            beats_calc = beats_to_4kb[8:0];
        end
`endif
        if (frm_end_reg && fifo_lvl_i != '0 && 32'(fifo_lvl_i) < 32'(beats_calc)) begin
            beats_calc = 9'(fifo_lvl_i);
        end
    end

    assign lvl_ok = (32'(fifo_lvl_i) >= 32'(beats_calc));

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        burst_len_next = burst_len_reg;
        beats_next     = beats_reg;
        awlen_next     = awlen_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frm_start_i && cfg_en_i) begin
                    addr_next      = buf_sel_reg ? cfg_base1_i : cfg_base0_i;
                    remaining_next = cfg_frm_words_i;
                    burst_len_next = (cfg_burst_len_i == 8'd0) ? 9'd1 : {1'b0, cfg_burst_len_i};
                    state_next     = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (remaining_reg == '0) begin
                    state_next = ST_DRAIN;
                end else if (lvl_ok && !outst_full) begin
                    beats_next = beats_calc;
                    awlen_next = TRANS_DATA_LEN_W'(beats_calc - 9'd1);
                    state_next = ST_ISSUE;
                end else if (frm_end_reg && fifo_lvl_i == '0) begin
                    // Source ended with nothing left to flush.
                    state_next = ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (awready_i) begin
                    state_next = ST_WAIT_W;
                end
            end
            ST_WAIT_W: begin
                if (burst_done_i) begin
                    addr_next      = addr_reg + (ADDR_W'(beats_reg) << BPB_SH);
                    remaining_next = remaining_after;
                    if (remaining_after == '0 || (frm_end_reg && fifo_lvl_i == '0)) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_WAIT_DATA;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            burst_len_reg <= 9'd1;
            beats_reg     <= '0;
            awlen_reg     <= '0;
            frm_end_reg   <= 1'b0;
            buf_sel_reg   <= 1'b0;
            err_reg       <= 1'b0;
            burst_go_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            burst_len_reg <= burst_len_next;
            beats_reg     <= beats_next;
            awlen_reg     <= awlen_next;
            burst_go_reg  <= aw_hs;
            if (state_reg == ST_IDLE) begin
                frm_end_reg <= 1'b0;
            end else if (frm_end_i) begin
                frm_end_reg <= 1'b1;
            end
            if (state_reg == ST_DONE) begin
                buf_sel_reg <= ~buf_sel_reg;
            end
            if (b_hs && bresp_i != RESP_OKAY) begin
                err_reg <= 1'b1;
            end
        end
    end

    dvp_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (aw_hs),
        .dec   (b_hs),
        .full  (outst_full),
        .empty (outst_empty)
    );

    assign awvalid_o     = awvalid;
    assign awaddr_o      = addr_reg;
    assign awlen_o       = awlen_reg;
    assign awid_o        = '0;
    assign burst_go_o    = burst_go_reg;
    assign burst_beats_o = beats_reg;
    assign bready_o      = !outst_empty;
    assign frm_done_o    = (state_reg == ST_DONE);
    assign buf_sel_o     = buf_sel_reg;
    assign err_o         = err_reg;
    assign busy_o        = (state_reg != ST_IDLE);

endmodule

// File: doc/dvp_burst_scheduler.md
DVP_BURST_SCHEDULER -- requirements
Module: dvp_burst_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32: pixel word width, giving DATA_W/8 bytes per beat.
REQ-003 SHALL have parameter TRANS_DATA_LEN_W, default 8: AWLEN width.
REQ-004 SHALL have parameter MST_ID_W, default 5: AWID width; AWID is constant 0.
REQ-005 SHALL have parameter MAX_OUTST, default 4: maximum bursts awaiting B; power of 2.
REQ-006 SHALL have parameter LVL_W, default 8: FIFO level width.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: cfg_en_i in 1 enable; cfg_base0_i/cfg_base1_i in ADDR_W ping/pong frame bases; cfg_frm_words_i in 20 words per frame; cfg_burst_len_i in 8 nominal beats, 0 treated as 1.
REQ-009 SHALL have ports: fifo_lvl_i in LVL_W words in downscaler FIFO; frm_start_i in 1 pulse; frm_end_i in 1 pulse.
REQ-010 SHALL have ports: awvalid_o out 1; awready_i in 1; awaddr_o out ADDR_W; awlen_o out TRANS_DATA_LEN_W (beats-1); awid_o out MST_ID_W.
REQ-011 SHALL have ports: burst_go_o out 1 (pulse to W datapath); burst_beats_o out 9; burst_done_i in 1 (WLAST accepted).
REQ-012 SHALL have ports: bvalid_i in 1; bresp_i in 2; bready_o out 1; frm_done_o out 1 pulse; buf_sel_o out 1; err_o out 1 sticky; busy_o out 1.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT_DATA -> ISSUE -> WAIT_W -> (WAIT_DATA | DRAIN) -> DONE -> IDLE.
REQ-014 IDLE: on frm_start_i with cfg_en_i=1, latch base of buf_sel_o, load remaining=cfg_frm_words_i, go to WAIT_DATA; frm_start_i is ignored in other states.
REQ-015 WAIT_DATA: beats=min(burst_len, remaining); go to ISSUE when fifo_lvl_i>=beats and outstanding<MAX_OUTST.
REQ-016 WAIT_DATA: if frm_end flag is set and 0<fifo_lvl_i<beats, beats=fifo_lvl_i (flush burst).
REQ-017 ISSUE: awvalid_o=1 with awaddr_o/awlen_o stable until awready_i; on handshake, burst_go_o pulses for 1 cycle and FSM goes to WAIT_W.
REQ-018 WAIT_W: on burst_done_i, addr+=beats*(DATA_W/8), remaining-=beats; go to DRAIN if remaining=0 or (frm_end flag and fifo_lvl_i=0), else WAIT_DATA.
REQ-019 Outstanding counter SHALL increment on AW handshake, decrement on bvalid_i&bready_o, and handle both in the same cycle as net 0; bready_o=1 whenever outstanding>0.
REQ-020 bresp_i!=0 SHALL set err_o, held until rst.
REQ-021 DRAIN: wait for outstanding=0, then DONE: pulse frm_done_o and toggle buf_sel_o, return to IDLE.
REQ-022 frm_end_i SHALL set the frm_end flag in any non-IDLE state; the flag clears in IDLE.
REQ-023 Address arithmetic SHALL be ADDR_W wide and wrap modulo 2^ADDR_W.
REQ-024 busy_o=1 in any state other than IDLE.
REQ-025 cfg_* SHALL be sampled only at frame start; mid-frame changes have no effect.

Reset
REQ-026 On rst: FSM=IDLE; awvalid_o, burst_go_o, frm_done_o, err_o, busy_o, buf_sel_o=0; outstanding=0; awaddr_o, awlen_o=0.
REQ-027 rst mid-burst SHALL abandon the frame immediately, with no further AW or frm_done_o.

Configuration
REQ-028 With DVP_BURST_SCHED_4KB_EN defined, beats SHALL additionally be clipped so that no burst crosses a 4 KB address boundary.
REQ-029 Without DVP_BURST_SCHED_4KB_EN, no boundary clipping is applied.

Structure
REQ-030 A shared package dvp_rx_pkg SHALL hold the FSM state encoding, the AXI OKAY response constant, and the BYTES_PER_BEAT constant.
REQ-031 The outstanding-burst tracker SHALL be sub-module dvp_outst_cnt (counter, full/empty flags).

Verification
REQ-032 Bench SHALL cover: frm_words=64, burst_len=16, level held 16, base0=0x1000 -> 4 AWs at 0x1000/0x1040/0x1080/0x10C0 with awlen=15, then frm_done_o, buf_sel_o=1.
REQ-033 Bench SHALL cover: frm_words=40, burst_len=16 -> bursts of 16, 16, 8 beats.
REQ-034 Bench SHALL cover: frm_end_i with level 5 and burst_len 16 -> one flush AW with awlen=4, then DRAIN.
REQ-035 Bench SHALL cover: awready_i low for 10 cycles and bvalid_i delayed, with MAX_OUTST=4 -> no 5th AW until a B arrives; awaddr_o stable while stalled.
REQ-036 Bench SHALL cover: bresp_i=2 on the 2nd burst -> err_o=1 and stays 1; the frame still completes.
REQ-037 Bench SHALL cover, with DVP_BURST_SCHED_4KB_EN defined: base 0x0FF0, burst 16 -> first AW awlen=3, next at 0x1000.
